// File: rtl/dsp_tap_sequencer_if.sv
// dsp_tap_sequencer_if
//   Bundles every signal of the tap sequencer except clock and reset:
//   - sample stream in  : in_valid / in_data / in_ready
//   - weight config     : cfg_we / cfg_addr / cfg_wdata / cfg_err
//   - external MAC slice: dsp_en / dsp_a / dsp_b / dsp_c / dsp_p
//   - result stream out : out_valid / out_data / out_ready
//   modport slave  : the sequencer itself
//   modport master : the environment (source, config port, slice, sink)
interface dsp_tap_sequencer_if #(
  parameter int SAMPLE_W = 4,
  parameter int WEIGHT_W = 2,
  parameter int NTAPS    = 3,
  parameter int ACC_W    = 8
);
  localparam int ADDR_W = $clog2(NTAPS);

  logic                in_valid;
  logic [SAMPLE_W-1:0] in_data;
  logic                in_ready;

  logic                cfg_we;
  logic [ADDR_W-1:0]   cfg_addr;
  logic [WEIGHT_W-1:0] cfg_wdata;
  logic                cfg_err;

  logic                dsp_en;
  logic [SAMPLE_W:0]   dsp_a;
  logic [WEIGHT_W-1:0] dsp_b;
  logic [ACC_W-1:0]    dsp_c;
  logic [ACC_W-1:0]    dsp_p;

  logic                out_valid;
  logic [ACC_W-1:0]    out_data;
  logic                out_ready;

  modport slave (
    input  in_valid, in_data, cfg_we, cfg_addr, cfg_wdata, dsp_p, out_ready,
    output in_ready, cfg_err, dsp_en, dsp_a, dsp_b, dsp_c, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, cfg_we, cfg_addr, cfg_wdata, dsp_p, out_ready,
    input  in_ready, cfg_err, dsp_en, dsp_a, dsp_b, dsp_c, out_valid, out_data
  );
endinterface

// File: rtl/dsp_tap_sequencer.sv
// dsp_tap_sequencer
//   FIR filter that shares one external multiply-add slice (P = A*B + C,
//   MAC_LAT cycles of latency) across NTAPS taps. Each accepted sample is
//   shifted into the delay line, then one tap per MAC slot is issued with the
//   previous partial sum fed back as C. The final sum is held on out_data
//   until the downstream sink takes it.
// Ports:
//   clock_pulse : sole clock, rising edge
//   clr_de      : synchronous active-high reset
//   bus         : sample in, weight config, slice operands/result, result out
module dsp_tap_sequencer #(
  parameter int SAMPLE_W = 4,
  parameter int WEIGHT_W = 2,
  parameter int NTAPS    = 3,
  parameter int ACC_W    = 8,
  parameter int MAC_LAT  = 1
) (
  input  logic               clock_pulse,
  input  logic               clr_de,
  dsp_tap_sequencer_if.slave bus
);
  localparam int K_W   = $clog2(NTAPS);
  localparam int CNT_W = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

  localparam logic [K_W-1:0]   K_LAST    = K_W'(NTAPS - 1);
  localparam logic [K_W:0]     NTAPS_EXT = (K_W + 1)'(NTAPS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAC_LAT);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

  state_e              state_q, state_d;
  logic [SAMPLE_W-1:0] tap_q [NTAPS];
  logic [WEIGHT_W-1:0] w_q   [NTAPS];
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    out_data_q;
  logic [K_W-1:0]      k_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                cfg_err_q;

  logic accept;
  logic slot_end;
  logic cfg_ok;

  assign accept   = (state_q == IDLE) && bus.in_valid;
  // The slice result for the current operands is valid in the last cycle
  // they are held.
  assign slot_end = (state_q == MAC) && (cnt_q == CNT_LAST);
  assign cfg_ok   = (state_q == IDLE) && ({1'b0, bus.cfg_addr} < NTAPS_EXT);

  // State register.
  always_ff @(posedge clock_pulse) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values, independent of block ordering.
    if (clr_de) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)                 state_d = MAC;
      MAC:     if (slot_end && (k_q == K_LAST))  state_d = DONE;
      DONE:    if (bus.out_ready)                state_d = IDLE;
      default:                                   state_d = IDLE;
    endcase
  end

  // Output logic. Operands are forced to 0 outside MAC so the slice sees a
  // quiet bus between samples.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.dsp_en    = 1'b0;
    bus.dsp_a     = '0;
    bus.dsp_b     = '0;
    bus.dsp_c     = '0;
    case (state_q)
      IDLE: bus.in_ready = 1'b1;
      MAC: begin
        bus.dsp_en = 1'b1;
        bus.dsp_a  = {1'b0, tap_q[k_q]};
        bus.dsp_b  = w_q[k_q];
        bus.dsp_c  = (k_q == '0) ? '0 : acc_q;
      end
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.out_data = out_data_q;
  assign bus.cfg_err  = cfg_err_q;

  // Datapath: delay line, weight file, slot counters, accumulator.
  always_ff @(posedge clock_pulse) begin
    if (clr_de) begin
      // NOTE: the delay line and weight file are small register files whose
      // contents are architecturally defined after reset (zero taps, unit
      // weights), so they are reset like any other state.
      for (int j = 0; j < NTAPS; j++) begin
        tap_q[j] <= '0;
        w_q[j]   <= WEIGHT_W'(1);
      end
      acc_q      <= '0;
      out_data_q <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      // Writes are only legal in IDLE; anything else is dropped and flagged.
      cfg_err_q <= 1'b0;
      if (bus.cfg_we) begin
        if (cfg_ok) w_q[bus.cfg_addr] <= bus.cfg_wdata;
        else        cfg_err_q         <= 1'b1;
      end

      if (accept) begin
        tap_q[0] <= bus.in_data;
        for (int j = 1; j < NTAPS; j++) tap_q[j] <= tap_q[j-1];
        k_q   <= '0;
        cnt_q <= '0;
      end

      if (state_q == MAC) begin
        cnt_q <= cnt_q + 1'b1;
        if (slot_end) begin
          acc_q <= bus.dsp_p;
          if (k_q == K_LAST) begin
            out_data_q <= bus.dsp_p;
          end else begin
            k_q   <= k_q + 1'b1;
            cnt_q <= '0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_dsp_tap_sequencer.sv
// tb_dsp_tap_sequencer
//   Directed bench for dsp_tap_sequencer. Two instances: the default build
//   (ACC_W=8) and an ACC_W=7 build for the wrap-around case. Each has a
//   behavioural one-cycle-latency multiply-add slice attached.
module tb_dsp_tap_sequencer;
  logic clock_pulse = 1'b0;
  logic clr_de;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   tr_a [6];
  int   tr_b [6];
  int   tr_c [6];

  always #5 clock_pulse = ~clock_pulse;
  always @(posedge clock_pulse) cyc <= cyc + 1;

  dsp_tap_sequencer_if #(.ACC_W(8)) bus ();
  dsp_tap_sequencer_if #(.ACC_W(7)) bus7 ();

  dsp_tap_sequencer #(.ACC_W(8), .MAC_LAT(1)) dut (
    .clock_pulse (clock_pulse),
    .clr_de      (clr_de),
    .bus         (bus.slave)
  );

  dsp_tap_sequencer #(.ACC_W(7), .MAC_LAT(1)) dut7 (
    .clock_pulse (clock_pulse),
    .clr_de      (clr_de),
    .bus         (bus7.slave)
  );

  // External slice model: P = A*B + C registered once (MAC_LAT = 1).
  always @(posedge clock_pulse) begin
    bus.dsp_p  <= 8'(bus.dsp_a * bus.dsp_b + bus.dsp_c);
    bus7.dsp_p <= 7'(bus7.dsp_a * bus7.dsp_b + bus7.dsp_c);
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer one sample while in IDLE; returns at the negedge after the accepting edge.
  task automatic send(input logic [3:0] d);
    check("in_ready_before_accept", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clock_pulse);
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
  endtask

  // Wait for the result, tracing the slot operands; optionally stall the sink
  // for 'hold' cycles while a source keeps offering junk samples.
  task automatic wait_result(input logic [7:0] exp, input int hold);
    int guard  = 0;
    bit ir_bad = 1'b0;
    int idx;
    if (hold > 0) bus.out_ready = 1'b0;
    while (bus.out_valid !== 1'b1 && guard < 40) begin
      idx = cyc - acc_cyc;
      if (idx >= 0 && idx < 6) begin
        tr_a[idx] = int'(bus.dsp_a);
        tr_b[idx] = int'(bus.dsp_b);
        tr_c[idx] = int'(bus.dsp_c);
      end
      if (bus.in_ready !== 1'b0) ir_bad = 1'b1;
      @(negedge clock_pulse);
      guard++;
    end
    check("latency_edges", cyc - acc_cyc, 6);
    check("out_data", bus.out_data, exp);
    check("in_ready_low_busy", ir_bad, 0);
    for (int h = 0; h < hold; h++) begin
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_out_data", bus.out_data, exp);
      check("hold_in_ready", bus.in_ready, 0);
      bus.in_valid = 1'b1;
      bus.in_data  = h[0] ? 4'd7 : 4'd8;
      @(negedge clock_pulse);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("in_ready_in_done", bus.in_ready, 0);
    @(negedge clock_pulse);
    check("out_valid_drop", bus.out_valid, 0);
    check("in_ready_after_done", bus.in_ready, 1);
  endtask

  task automatic run7(input logic [3:0] d, input logic [6:0] exp);
    int guard = 0;
    bus7.in_valid = 1'b1;
    bus7.in_data  = d;
    @(negedge clock_pulse);
    bus7.in_valid = 1'b0;
    while (bus7.out_valid !== 1'b1 && guard < 40) begin
      @(negedge clock_pulse);
      guard++;
    end
    check("acc7_out_data", bus7.out_data, exp);
    @(negedge clock_pulse);
  endtask

  initial begin
    logic [7:0] exp1 [4];
    exp1 = '{8'd1, 8'd3, 8'd6, 8'd9};

    clr_de         = 1'b1;
    bus.in_valid   = 1'b0;  bus.in_data   = '0;
    bus.cfg_we     = 1'b0;  bus.cfg_addr  = '0;  bus.cfg_wdata  = '0;
    bus.out_ready  = 1'b1;
    bus7.in_valid  = 1'b0;  bus7.in_data  = '0;
    bus7.cfg_we    = 1'b0;  bus7.cfg_addr = '0;  bus7.cfg_wdata = '0;
    bus7.out_ready = 1'b1;
    repeat (2) @(negedge clock_pulse);

    // Reset state.
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_dsp_en", bus.dsp_en, 0);
    check("rst_dsp_abc", {bus.dsp_a, bus.dsp_b, bus.dsp_c}, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_out_data", bus.out_data, 0);
    clr_de = 1'b0;
    @(negedge clock_pulse);

    // Default unit weights: running sums of the last three samples.
    for (int i = 0; i < 4; i++) begin
      send(4'(i + 1));
      wait_result(exp1[i], 0);
    end

    // Weights 3,2,1; the last write shares its edge with the sample accept.
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_wdata = 2'd3;
    @(negedge clock_pulse);
    bus.cfg_addr = 2'd1; bus.cfg_wdata = 2'd2;
    @(negedge clock_pulse);
    check("cfg_err_legal_write", bus.cfg_err, 0);
    bus.cfg_addr = 2'd2; bus.cfg_wdata = 2'd1;
    send(4'd15);
    bus.cfg_we = 1'b0;
    wait_result(8'd56, 0);   // taps 15,4,3
    send(4'd15);
    wait_result(8'd79, 0);   // taps 15,15,4
    send(4'd15);
    wait_result(8'd90, 0);   // taps 15,15,15
    check("slot0_a", tr_a[0], 15);  check("slot0_b", tr_b[0], 3);  check("slot0_c", tr_c[0], 0);
    check("slot0_c_held", tr_c[1], 0);
    check("slot1_a", tr_a[2], 15);  check("slot1_b", tr_b[2], 2);  check("slot1_c", tr_c[2], 45);
    check("slot1_c_held", tr_c[3], 45);
    check("slot2_a", tr_a[4], 15);  check("slot2_b", tr_b[4], 1);  check("slot2_c", tr_c[4], 75);
    check("slot2_c_held", tr_c[5], 75);

    // Sink stalls 5 cycles in DONE with the source still pushing.
    send(4'd1);
    wait_result(8'd48, 5);   // taps 1,15,15 -> 3+30+15
    send(4'd2);
    wait_result(8'd23, 0);   // taps 2,1,15 -> 6+2+15, delay line untouched by stall

    // Write attempted during MAC is rejected.
    send(4'd0);
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_wdata = 2'd0;
    @(negedge clock_pulse);
    bus.cfg_we = 1'b0;
    check("cfg_err_mac_pulse", bus.cfg_err, 1);
    @(negedge clock_pulse);
    check("cfg_err_mac_clear", bus.cfg_err, 0);
    wait_result(8'd5, 0);    // taps 0,2,1 -> 0+4+1

    // Out-of-range address in IDLE is rejected.
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd3; bus.cfg_wdata = 2'd0;
    @(negedge clock_pulse);
    bus.cfg_we = 1'b0;
    check("cfg_err_addr_pulse", bus.cfg_err, 1);
    @(negedge clock_pulse);
    check("cfg_err_addr_clear", bus.cfg_err, 0);
    send(4'd3);
    wait_result(8'd11, 0);   // taps 3,0,2 -> 9+0+2

    // Reset in the middle of slot k=1.
    send(4'd9);
    @(negedge clock_pulse);
    @(negedge clock_pulse);
    check("mid_mac_slot1_b", bus.dsp_b, 2);
    clr_de = 1'b1;
    @(negedge clock_pulse);
    clr_de = 1'b0;
    check("clr_out_valid", bus.out_valid, 0);
    check("clr_in_ready", bus.in_ready, 1);
    check("clr_dsp_en", bus.dsp_en, 0);
    check("clr_out_data", bus.out_data, 0);
    send(4'd5);
    wait_result(8'd5, 0);    // taps 5,0,0 with unit weights

    // ACC_W=7 build: all weights 3, three samples of 15 -> 45, 90, 135 mod 128.
    for (int i = 0; i < 3; i++) begin
      bus7.cfg_we = 1'b1; bus7.cfg_addr = 2'(i); bus7.cfg_wdata = 2'd3;
      @(negedge clock_pulse);
    end
    bus7.cfg_we = 1'b0;
    run7(4'd15, 7'd45);
    run7(4'd15, 7'd90);
    run7(4'd15, 7'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
